// File: rtl/game_ctrl.sv
// game_ctrl: game-flow controller that sits in front of move_ball and placar.
// It sequences IDLE -> SERVE -> PLAY -> LOST/OVER/WIN. Every delay is counted
// in video frames, and one frame is one falling edge of vga_vs.
// Optional feature macro: GAME_CTRL_BLINK_EN. When it is defined, the blink
// output toggles in OVER/WIN. When it is not defined, blink is tied low.
module game_ctrl #(
    parameter int LIVES        = 3,
    parameter int SERVE_FRAMES = 60,
    parameter int LOST_FRAMES  = 90,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       vga_vs,
    input  logic       endgame_ball,
    input  logic       endgame_block,
    input  logic       all_cleared,
    output logic       ball_run,
    output logic       ball_hold,
    output logic       new_game,
    output logic [1:0] lives,
    output logic [2:0] state,
    output logic       game_over,
    output logic       win,
    output logic       blink
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOST  = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [8:0] SERVE_LAST = 9'(SERVE_FRAMES);
    localparam logic [8:0] LOST_LAST  = 9'(LOST_FRAMES);

    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       vs_prev_q, vs_prev_d;
    logic       start_prev_q, start_prev_d;
    logic       ball_run_q, ball_run_d;
    logic       ball_hold_q, ball_hold_d;
    logic       new_game_q, new_game_d;
    logic       game_over_q, game_over_d;
    logic       win_q, win_d;

    logic       frame_tick;
    logic       start_rise;
    logic [8:0] frame_cnt_inc;
    logic       state_change;

    // vs_prev and start_prev reset to 1. A switch that is already on when
    // reset is released therefore has to be toggled off and on before a game starts.
    assign frame_tick    = vs_prev_q & ~vga_vs;
    assign start_rise    = start & ~start_prev_q;
    assign frame_cnt_inc = {1'b0, frame_cnt_q} + 9'd1;
    assign state_change  = (state_d != state_q);

    // Edge-detect history: sample the current vsync and start levels
    always_comb begin
        vs_prev_d    = vga_vs;
        start_prev_d = start;
    end

    // Next-state, lives and registered-output decode
    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        new_game_d = 1'b0;

        if ((state_q != ST_IDLE) && !start) begin
            // Dropping the switch aborts from any state, and this wins over every other transition
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_rise) begin
                        state_d    = ST_SERVE;
                        lives_d    = LIVES_INIT;
                        new_game_d = 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick && (frame_cnt_inc == SERVE_LAST)) begin
                        state_d = ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (endgame_block) begin
                        state_d = ST_OVER;
                        lives_d = 2'd0;
                    end else if (all_cleared) begin
                        state_d = ST_WIN;
                    end else if (endgame_ball) begin
                        state_d = ST_LOST;
                        if (lives_q != 2'd0) begin
                            lives_d = lives_q - 2'd1;
                        end
                    end
                end
                ST_LOST: begin
                    // The decrement happened on entry, so a ball that stays in lava is ignored here
                    if (frame_tick && (frame_cnt_inc == LOST_LAST)) begin
                        state_d = (lives_q == 2'd0) ? ST_OVER : ST_SERVE;
                    end
                end
                ST_OVER, ST_WIN: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Outputs are decoded from the next state so they register with it
        ball_run_d  = (state_d == ST_PLAY);
        ball_hold_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) ||
                      (state_d == ST_OVER) || (state_d == ST_WIN);
        game_over_d = (state_d == ST_OVER);
        win_d       = (state_d == ST_WIN);
    end

    // Frames spent in the current state, cleared on entry, saturating at 255
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (state_change) begin
            frame_cnt_d = 8'd0;
        end else if (frame_tick && (frame_cnt_q != 8'hFF)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    // State register and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            lives_q      <= LIVES_INIT;
            frame_cnt_q  <= 8'd0;
            vs_prev_q    <= 1'b1;
            start_prev_q <= 1'b1;
            ball_run_q   <= 1'b0;
            ball_hold_q  <= 1'b1;
            new_game_q   <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            frame_cnt_q  <= frame_cnt_d;
            vs_prev_q    <= vs_prev_d;
            start_prev_q <= start_prev_d;
            ball_run_q   <= ball_run_d;
            ball_hold_q  <= ball_hold_d;
            new_game_q   <= new_game_d;
            game_over_q  <= game_over_d;
            win_q        <= win_d;
        end
    end

`ifdef GAME_CTRL_BLINK_EN
    localparam logic [8:0] BLINK_LAST = 9'(BLINK_FRAMES);

    logic       blink_q, blink_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       end_state_d;

    assign end_state_d = (state_d == ST_OVER) || (state_d == ST_WIN);

    // Attract blink: starts high on entry to OVER/WIN and toggles every BLINK_FRAMES ticks
    always_comb begin
        blink_d     = 1'b0;
        blink_cnt_d = 8'd0;
        if (end_state_d) begin
            if (state_change) begin
                blink_d     = 1'b1;
                blink_cnt_d = 8'd0;
            end else if (frame_tick) begin
                if (({1'b0, blink_cnt_q} + 9'd1) == BLINK_LAST) begin
                    blink_d     = ~blink_q;
                    blink_cnt_d = 8'd0;
                end else begin
                    blink_d     = blink_q;
                    blink_cnt_d = blink_cnt_q + 8'd1;
                end
            end else begin
                blink_d     = blink_q;
                blink_cnt_d = blink_cnt_q;
            end
        end
    end

    // Blink output and its frame counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_q     <= 1'b0;
            blink_cnt_q <= 8'd0;
        end else begin
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

    assign ball_run  = ball_run_q;
    assign ball_hold = ball_hold_q;
    assign new_game  = new_game_q;
    assign lives     = lives_q;
    assign state     = state_q;
    assign game_over = game_over_q;
    assign win       = win_q;

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
Game-flow controller sitting directly upstream of move_ball and placar. It consumes the start switch, the VGA vertical sync and the loss/win flags (endgame_ball, endgame_block, all_cleared). It produces the ball run/hold controls, a one-cycle new-game pulse, the remaining-lives count and the game state. All timing is counted in video frames, derived from falling edges of vga_vs.

Parameters:
LIVES, 3, lives loaded at new game (1..3, fits 2 bits)
SERVE_FRAMES, 60, frames ball is held on the bar before launch (1..255)
LOST_FRAMES, 90, frames of pause after losing a ball (1..255)
BLINK_FRAMES, 30, half-period of blink output in frames (1..255, used only with option)

Ports:
clock  in  1  pixel clock (VGA_CLK)
reset  in  1  asynchronous, active-low reset
start  in  1  start/run level (switch, already inverted to active-high)
vga_vs  in  1  VGA vsync, active-low, same clock domain
endgame_ball  in  1  level: ball reached lava
endgame_block  in  1  level: a block reached the bottom
all_cleared  in  1  level: no blocks remain
ball_run  out  1  1 = ball moves freely
ball_hold  out  1  1 = ball held/re-centred on the bar
new_game  out  1  one-cycle pulse: reset score and blocks
lives  out  2  remaining lives
state  out  3  IDLE=0, SERVE=1, PLAY=2, LOST=3, OVER=4, WIN=5
game_over  out  1  high in OVER
win  out  1  high in WIN
blink  out  1  attract blink (see option)

Behaviour:
- Reset (async, reset=0):
  - state=IDLE, lives=LIVES, frame_cnt=0.
  - ball_run=0, ball_hold=1, new_game=0, game_over=0, win=0, blink=0.
  - vs_d=1 and start_d=1. A switch already on at reset release needs an off/on toggle to start.
- Registers:
  - frame_tick = vs_d & ~vga_vs: one cycle per frame, at the vsync falling edge.
  - start_rise = start & ~start_d.
- frame_cnt (8 bit):
  - Cleared on every state change.
  - Increments on frame_tick and saturates at 255.
- Global abort: start=0 in any non-IDLE state forces IDLE on the next clock and overrides all other transitions.
- IDLE:
  - ball_run=0, ball_hold=1.
  - On start_rise: go to SERVE, lives=LIVES, assert new_game for exactly that one cycle.
- SERVE:
  - ball_hold=1, ball_run=0. Loss and win flags are ignored.
  - Go to PLAY on the frame_tick where frame_cnt+1 == SERVE_FRAMES.
- PLAY:
  - ball_run=1, ball_hold=0.
  - Priority when several flags are high in the same cycle: endgame_block > all_cleared > endgame_ball.
  - endgame_block: go to OVER and force lives=0.
  - all_cleared: go to WIN, lives unchanged.
  - endgame_ball: go to LOST and decrement lives once (no underflow below 0).
- LOST:
  - ball_run=0, ball_hold=0 (ball frozen).
  - On the frame_tick where frame_cnt+1 == LOST_FRAMES: go to OVER if lives==0, else SERVE.
  - A still-high endgame_ball causes no further decrement.
- OVER / WIN:
  - ball_run=0, ball_hold=1.
  - game_over or win high respectively.
  - Leave only via the global abort (start low), then a new start_rise from IDLE.
- Outputs are registered; state, lives and flags change one clock after the causing input edge.
- new_game never fires twice for one switch press. It never fires in any state other than IDLE.

Optional Feature:
GAME_CTRL_BLINK_EN
- Defined: in OVER and WIN, blink toggles every BLINK_FRAMES frame_ticks, starting at 1 on entry. In all other states blink=0 and its counter is cleared.
- Undefined: blink is tied to 0 and no blink counter is synthesised.

Test Plan:
Parameters for all scenarios: LIVES=2, SERVE_FRAMES=2, LOST_FRAMES=3.
1. Reset with start=1, then hold 5 frames -> state stays 0, no new_game. Drop start, raise start -> new_game one cycle, state=1, lives=2. After 2 vs falling edges -> state=2, ball_run=1.
2. In PLAY, pulse endgame_ball high for 10 cycles -> state=3, lives=1 (single decrement). After 3 frames -> state=1. After 2 more frames -> state=2.
3. Lose a second ball -> lives=0. After 3 frames -> state=4, game_over=1, ball_hold=1.
4. In PLAY, assert endgame_ball and all_cleared in the same cycle -> state=5, win=1, lives unchanged. Assert endgame_block with both of them -> state=4, lives=0.
5. In LOST with frame_cnt=1, drop start -> IDLE next clock, ball_hold=1. Raise start -> new_game, lives=2.
6. Assert reset mid-PLAY -> all outputs at reset values immediately, without a clock edge. With GAME_CTRL_BLINK_EN and BLINK_FRAMES=2, in WIN -> blink pattern 1,1,0,0,1,1 sampled per frame.
